// File: rtl/bias_stream_loader_pkg.sv
// Shared types for the stream loaders: the 1-bit LOAD/READY state encoding
// reused by the bias and weight loaders.
package bias_stream_loader_pkg;

  localparam logic STATE_LOAD  = 1'b0;
  localparam logic STATE_READY = 1'b1;

  typedef enum logic {
    LOAD  = STATE_LOAD,
    READY = STATE_READY
  } loader_state_e;

endpackage

// File: rtl/bias_buf_ram.sv
// Coefficient buffer: one write port plus a registered, read-first read port
// with the same addr/ce/q shape as the bias ROM it replaces.
module bias_buf_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COEFF  = 32,
  localparam int ADDR_WIDTH = $clog2(NUM_COEFF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  ce,
  output logic [DATA_WIDTH-1:0] q
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(NUM_COEFF);

  logic [DATA_WIDTH-1:0] mem [NUM_COEFF];
  logic [DATA_WIDTH-1:0] q_reg;
  logic                  in_range;

  assign in_range = ({1'b0, addr} < DEPTH);
  assign q        = q_reg;

  // Contents are deliberately left uninitialised so the array maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read alongside the write above gives old data on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (ce) begin
      q_reg <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/bias_stream_loader.sv
// Pops NUM_COEFF bias coefficients from an ap_fifo stream into a buffer, then
// serves them on a ROM-style port. Define BIAS_LOADER_RELOAD_EN for bias_reload.
module bias_stream_loader
  import bias_stream_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COEFF  = 32,
  localparam int ADDR_WIDTH = $clog2(NUM_COEFF)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] input_V_dout,
  input  logic                  input_V_empty_n,
  output logic                  input_V_read,
  input  logic [ADDR_WIDTH-1:0] bias_address,
  input  logic                  bias_ce,
`ifdef BIAS_LOADER_RELOAD_EN
  input  logic                  bias_reload,
`endif
  output logic [DATA_WIDTH-1:0] bias_q,
  output logic                  bias_loaded
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_COEFF - 1);

  loader_state_e         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] wr_cnt_reg, wr_cnt_next;
  logic                  loaded_reg;
  logic                  pop;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg  <= LOAD;
      wr_cnt_reg <= '0;
      loaded_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_cnt_reg <= wr_cnt_next;
      loaded_reg <= (state_next == READY);
    end
  end

  always_comb begin
    state_next  = state_reg;
    wr_cnt_next = wr_cnt_reg;
    pop         = 1'b0;
    case (state_reg)
      LOAD: begin
        pop = input_V_empty_n;
        if (pop) begin
          if (wr_cnt_reg == LAST_ADDR) begin
            wr_cnt_next = '0;
            state_next  = READY;
          end else begin
            wr_cnt_next = wr_cnt_reg + 1'b1;
          end
        end
      end
      READY: begin
`ifdef BIAS_LOADER_RELOAD_EN
        if (bias_reload) begin
          wr_cnt_next = '0;
          state_next  = LOAD;
        end
`endif
      end
      default: begin
        state_next  = LOAD;
        wr_cnt_next = '0;
      end
    endcase
  end

  // Held in reset the FIFO must not be popped even though state reads LOAD.
  assign input_V_read = pop & ap_rst_n;
  assign bias_loaded  = loaded_reg;

  bias_buf_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_COEFF  (NUM_COEFF)
  ) u_buf (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .wr_en   (input_V_read),
    .wr_addr (wr_cnt_reg),
    .wr_data (input_V_dout),
    .addr    (bias_address),
    .ce      (bias_ce),
    .q       (bias_q)
  );

endmodule

// File: tb/tb_bias_stream_loader.sv
// Bench for bias_stream_loader: a 32-entry and a 20-entry instance fed from
// queue FIFOs and checked against a pop-count/array model of the loader.
module tb_bias_stream_loader;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [15:0] dout    [2];
  logic        empty_n [2];
  logic        read_o  [2];
  logic [4:0]  addr    [2];
  logic        ce      [2];
  logic [15:0] q       [2];
  logic        loaded  [2];
  logic        reload  [2];

  always #5 ap_clk = ~ap_clk;

  bias_stream_loader #(.DATA_WIDTH(16), .NUM_COEFF(32)) dut32 (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .input_V_dout    (dout[0]),
    .input_V_empty_n (empty_n[0]),
    .input_V_read    (read_o[0]),
    .bias_address    (addr[0]),
    .bias_ce         (ce[0]),
`ifdef BIAS_LOADER_RELOAD_EN
    .bias_reload     (reload[0]),
`endif
    .bias_q          (q[0]),
    .bias_loaded     (loaded[0])
  );

  bias_stream_loader #(.DATA_WIDTH(16), .NUM_COEFF(20)) dut20 (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .input_V_dout    (dout[1]),
    .input_V_empty_n (empty_n[1]),
    .input_V_read    (read_o[1]),
    .bias_address    (addr[1]),
    .bias_ce         (ce[1]),
`ifdef BIAS_LOADER_RELOAD_EN
    .bias_reload     (reload[1]),
`endif
    .bias_q          (q[1]),
    .bias_loaded     (loaded[1])
  );

  // Reference model: buffer contents, pop count into the current load, flags.
  int unsigned N [2] = '{32, 20};
  logic [15:0] m_mem     [2][32];
  bit          m_valid   [2][32];
  int unsigned m_wr      [2];
  bit          m_loaded  [2];
  logic [15:0] m_q       [2];
  bit          m_q_known [2];
  bit          gate      [2];
  int unsigned pops      [2];
  logic [15:0] fifo0 [$];
  logic [15:0] fifo1 [$];

  int checks = 0;
  int errors = 0;

  function automatic int fifo_size(int i);
    return (i == 0) ? fifo0.size() : fifo1.size();
  endfunction

  function automatic logic [15:0] fifo_front(int i);
    return (i == 0) ? fifo0[0] : fifo1[0];
  endfunction

  function automatic void fifo_pop(int i);
    if (i == 0) void'(fifo0.pop_front());
    else        void'(fifo1.pop_front());
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left on the falling edge.
  task automatic cycle();
    bit exp_rd [2];
    bit pop_now [2];
    for (int i = 0; i < 2; i++) begin
      empty_n[i] = gate[i] && (fifo_size(i) > 0);
      dout[i]    = (fifo_size(i) > 0) ? fifo_front(i) : 16'h0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_rd[i] = !m_loaded[i] && empty_n[i];
      chk($sformatf("read[%0d]", i), {31'b0, read_o[i]}, {31'b0, exp_rd[i]});
      chk($sformatf("loaded[%0d]", i), {31'b0, loaded[i]}, {31'b0, m_loaded[i]});
      pop_now[i] = read_o[i];
    end
    @(posedge ap_clk);
    for (int i = 0; i < 2; i++) begin
      if (ce[i]) begin
        if (addr[i] < N[i]) begin
          m_q[i]       = m_mem[i][addr[i]];
          m_q_known[i] = m_valid[i][addr[i]];
        end else begin
          m_q[i]       = 16'h0;
          m_q_known[i] = 1'b1;
        end
      end
      if (exp_rd[i]) begin
        m_mem[i][m_wr[i]]   = dout[i];
        m_valid[i][m_wr[i]] = 1'b1;
        m_wr[i]++;
        if (m_wr[i] == N[i]) begin
          m_wr[i]     = 0;
          m_loaded[i] = 1'b1;
        end
      end else if (reload[i] && m_loaded[i]) begin
        m_loaded[i] = 1'b0;
        m_wr[i]     = 0;
      end
      if (pop_now[i]) begin
        fifo_pop(i);
        pops[i]++;
      end
    end
    @(negedge ap_clk);
    for (int i = 0; i < 2; i++) begin
      if (m_q_known[i]) chk($sformatf("bias_q[%0d]", i), {16'b0, q[i]}, {16'b0, m_q[i]});
    end
  endtask

  task automatic rd(int i, int a);
    ce[i]   = 1'b1;
    addr[i] = 5'(a);
    cycle();
    ce[i]   = 1'b0;
    $display("read inst=%0d addr=%0d q=%0d", i, a, q[i]);
  endtask

  task automatic do_reset();
    #2 ap_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      m_loaded[i]  = 1'b0;
      m_wr[i]      = 0;
      m_q[i]       = 16'h0;
      m_q_known[i] = 1'b1;
      chk($sformatf("rst_q[%0d]", i), {16'b0, q[i]}, 32'h0);
      chk($sformatf("rst_loaded[%0d]", i), {31'b0, loaded[i]}, 32'h0);
      chk($sformatf("rst_read[%0d]", i), {31'b0, read_o[i]}, 32'h0);
    end
    $display("reset asserted at %0t", $time);
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  // Run with the current gates until instance i finishes a load or budget expires.
  task automatic run_load(int i, int budget, bit pattern, output int cycles);
    cycles = 0;
    while (!m_loaded[i] && cycles < budget) begin
      if (pattern) gate[i] = (cycles % 4 == 0) || (cycles % 4 == 3);
      cycle();
      cycles++;
    end
    chk($sformatf("load_done[%0d]", i), {31'b0, loaded[i]}, 32'h1);
    $display("load inst=%0d done after %0d cycles, pops=%0d", i, cycles, pops[i]);
  endtask

  initial begin
    int cyc;
    int a;
    int p0;
    ap_rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dout[i] = 16'h0; empty_n[i] = 1'b0; addr[i] = 5'd0; ce[i] = 1'b0;
      reload[i] = 1'b0; gate[i] = 1'b0; pops[i] = 0;
      for (int k = 0; k < 32; k++) m_valid[i][k] = 1'b0;
    end
    @(negedge ap_clk);
    do_reset();

    // Load 100..131 with stalls (1,0,0,1); 8 surplus words must stay queued.
    for (int k = 0; k < 40; k++) fifo0.push_back(16'(100 + k));
    run_load(0, 200, 1'b1, cyc);
    chk("pops_100", pops[0], 32);
    gate[0] = 1'b1;
    repeat (4) cycle();
    chk("surplus_pops", pops[0], 32);
    chk("surplus_left", fifo0.size(), 8);

    rd(0, 5);
    chk("addr5", {16'b0, q[0]}, 32'd105);
    for (int k = 0; k < 10; k++) begin
      a = int'($urandom_range(0, 31));
      rd(0, a);
      chk("rand_rd100", {16'b0, q[0]}, 32'(100 + a));
    end
    repeat (3) cycle();
    chk("hold100", {16'b0, q[0]}, 32'(100 + a));

    // Non-power-of-2 instance: out-of-range address reads as zero.
    for (int k = 1; k <= 20; k++) fifo1.push_back(16'(k));
    gate[1] = 1'b1;
    run_load(1, 40, 1'b0, cyc);
    chk("cycles20", cyc, 20);
    rd(1, 25);
    chk("oob25", {16'b0, q[1]}, 32'd0);
    rd(1, 7);
    chk("addr7", {16'b0, q[1]}, 32'd8);
    repeat (3) cycle();
    chk("hold20", {16'b0, q[1]}, 32'd8);

    // Partial load of random words interrupted by reset.
    do_reset();
    fifo0.delete();
    for (int k = 0; k < 16; k++) fifo0.push_back(16'($urandom));
    p0 = int'(pops[0]);
    repeat (10) cycle();
    chk("partial_pops", pops[0], 32'(p0 + 10));
    rd(0, 3);
    do_reset();
    fifo0.delete();
    for (int k = 0; k < 34; k++) fifo0.push_back(16'(500 + k));
    run_load(0, 60, 1'b0, cyc);
    chk("cycles500", cyc, 32);
    rd(0, 0);
    chk("mem0_500", {16'b0, q[0]}, 32'd500);
    for (int k = 0; k < 6; k++) begin
      a = int'($urandom_range(0, 31));
      rd(0, a);
      chk("rand_rd500", {16'b0, q[0]}, 32'(500 + a));
    end

`ifdef BIAS_LOADER_RELOAD_EN
    gate[0] = 1'b0;
    fifo0.delete();
    for (int k = 0; k < 32; k++) fifo0.push_back(16'(200 + k));
    reload[0] = 1'b1;
    cycle();
    reload[0] = 1'b0;
    chk("reload_drop", {31'b0, loaded[0]}, 32'h0);
    gate[0] = 1'b1;
    run_load(0, 60, 1'b0, cyc);
    chk("cycles200", cyc, 32);
    rd(0, 0);
    chk("mem0_200", {16'b0, q[0]}, 32'd200);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
